// File: rtl/gray_pkg.sv
// Shared definitions for the Gray-code counter family.
package gray_pkg;

  localparam int unsigned WIDTH_MIN = 2;
  localparam int unsigned WIDTH_MAX = 32;

  // Terminal-count behaviour selected by the SATURATE parameter.
  typedef enum logic {
    WRAP = 1'b0,
    SAT  = 1'b1
  } sat_mode_e;

  // Binary to Gray. Works at full WIDTH_MAX. Callers zero-extend narrower values
  // and take the low bits; zero upper bits leave the low-bit result unchanged.
  function automatic logic [WIDTH_MAX-1:0] bin2gray(input logic [WIDTH_MAX-1:0] b);
    return b ^ (b >> 1);
  endfunction

endpackage

// File: rtl/gray2bin_n.sv
// Combinational WIDTH-bit Gray-to-binary converter (MSB-first XOR prefix chain).
module gray2bin_n #(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] gray,
  output logic [WIDTH-1:0] bin
);

  // Each binary bit is the XOR of its Gray bit with the binary bit above it.
  always_comb begin
    logic [WIDTH-1:0] acc;
    acc = '0;
    acc[WIDTH-1] = gray[WIDTH-1];
    for (int unsigned k = WIDTH - 1; k > 0; k--) begin
      acc[k-1] = acc[k] ^ gray[k-1];
    end
    bin = acc;
  end

endmodule

// File: rtl/gray_counter_n.sv
// Registered up/down Gray counter. It has parallel Gray load and wraps or
// saturates at the terminal count. Both the Gray value and its binary
// equivalent are registered outputs.
module gray_counter_n
  import gray_pkg::*;
#(
  parameter int WIDTH    = 4,
  parameter int SATURATE = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             up,
  input  logic             load,
  input  logic [WIDTH-1:0] load_gray,
  output logic [WIDTH-1:0] gray,
  output logic [WIDTH-1:0] bin,
  output logic             terminal
);

  localparam bit SAT_EN = (SATURATE == int'(SAT));

  if (WIDTH < int'(WIDTH_MIN) || WIDTH > int'(WIDTH_MAX)) begin : g_bad_width
    $error("gray_counter_n: WIDTH out of range");
  end

  logic [WIDTH-1:0]     bin_q, bin_d;
  logic [WIDTH-1:0]     gray_q, gray_d;
  logic                 terminal_q, terminal_d;
  logic [WIDTH-1:0]     load_bin;
  logic [WIDTH_MAX-1:0] gray_full;

  gray2bin_n #(.WIDTH(WIDTH)) u_load_conv (
    .gray (load_gray),
    .bin  (load_bin)
  );

  // Next-state selection: load beats count, count beats hold.
  always_comb begin
    bin_d      = bin_q;
    terminal_d = 1'b0;
    if (load) begin
      bin_d = load_bin;
    end else if (en) begin
      if (up) begin
        if (bin_q == '1) begin
          terminal_d = 1'b1;
          if (!SAT_EN) bin_d = '0;
        end else begin
          bin_d = bin_q + WIDTH'(1);
        end
      end else begin
        if (bin_q == '0) begin
          terminal_d = 1'b1;
          if (!SAT_EN) bin_d = '1;
        end else begin
          bin_d = bin_q - WIDTH'(1);
        end
      end
    end
    gray_full = bin2gray(WIDTH_MAX'(bin_d));
    gray_d    = load ? load_gray : gray_full[WIDTH-1:0];
  end

  if (WIDTH < int'(WIDTH_MAX)) begin : g_unused
    logic unused_gray_hi;
    assign unused_gray_hi = ^gray_full[WIDTH_MAX-1:WIDTH];
  end

  // Output registers with asynchronous clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bin_q      <= '0;
      gray_q     <= '0;
      terminal_q <= 1'b0;
    end else begin
      bin_q      <= bin_d;
      gray_q     <= gray_d;
      terminal_q <= terminal_d;
    end
  end

  assign gray     = gray_q;
  assign bin      = bin_q;
  assign terminal = terminal_q;

endmodule

// File: tb/tb_gray_counter_n.sv
// Randomised and directed checks of gray_counter_n in wrap and saturate modes
// against an arithmetic reference model.
module tb_gray_counter_n;

  localparam int W    = 4;
  localparam int MAXV = (1 << W) - 1;

  logic         clk   = 1'b0;
  logic         rst_n = 1'b1;
  logic         en    = 1'b0;
  logic         up    = 1'b0;
  logic         load  = 1'b0;
  logic [W-1:0] load_gray = '0;

  logic [W-1:0] gray_w, bin_w, gray_s, bin_s;
  logic         term_w, term_s;

  int n_vec = 0;
  int n_err = 0;

  int mb_w = 0;
  int mb_s = 0;
  bit mt_w = 1'b0;
  bit mt_s = 1'b0;

  always #5 clk = ~clk;

  gray_counter_n #(.WIDTH(W), .SATURATE(0)) dut_wrap (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (en),
    .up        (up),
    .load      (load),
    .load_gray (load_gray),
    .gray      (gray_w),
    .bin       (bin_w),
    .terminal  (term_w)
  );

  gray_counter_n #(.WIDTH(W), .SATURATE(1)) dut_sat (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (en),
    .up        (up),
    .load      (load),
    .load_gray (load_gray),
    .gray      (gray_s),
    .bin       (bin_s),
    .terminal  (term_s)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic int to_gray(input int b);
    return b ^ (b >> 1);
  endfunction

  // Inverse found by search over the code space, independent of any XOR chain.
  function automatic int from_gray(input int g);
    for (int b = 0; b <= MAXV; b++) begin
      if (to_gray(b) == g) return b;
    end
    return -1;
  endfunction

  task automatic model_step(inout int b, inout bit t, input bit sat);
    if (load) begin
      b = from_gray(int'(load_gray));
      t = 1'b0;
    end else if (en) begin
      if (up) begin
        if (b == MAXV) begin
          t = 1'b1;
          if (!sat) b = 0;
        end else begin
          b = b + 1;
          t = 1'b0;
        end
      end else begin
        if (b == 0) begin
          t = 1'b1;
          if (!sat) b = MAXV;
        end else begin
          b = b - 1;
          t = 1'b0;
        end
      end
    end else begin
      t = 1'b0;
    end
  endtask

  task automatic check_all();
    chk("bin_wrap",  32'(bin_w),  32'(mb_w));
    chk("gray_wrap", 32'(gray_w), 32'(to_gray(mb_w)));
    chk("term_wrap", 32'(term_w), 32'(mt_w));
    chk("bin_sat",   32'(bin_s),  32'(mb_s));
    chk("gray_sat",  32'(gray_s), 32'(to_gray(mb_s)));
    chk("term_sat",  32'(term_s), 32'(mt_s));
  endtask

  // One clock: inputs already set; update model, compare, check unit distance.
  task automatic cycle();
    logic [W-1:0] prev_gray;
    bit           stepped;
    prev_gray = gray_w;
    stepped   = en && !load && rst_n;
    @(posedge clk);
    #1;
    model_step(mb_w, mt_w, 1'b0);
    model_step(mb_s, mt_s, 1'b1);
    check_all();
    if (stepped) chk("unit_dist", 32'($countones(gray_w ^ prev_gray)), 32'd1);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    mb_w = 0; mb_s = 0; mt_w = 1'b0; mt_s = 1'b0;
    check_all();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  int seq [17] = '{0, 1, 3, 2, 6, 7, 5, 4, 12, 13, 15, 14, 10, 11, 9, 8, 0};

  initial begin
    #2;
    do_reset();

    // Full up-count sequence with wrap.
    chk("seq_0", 32'(gray_w), 32'(seq[0]));
    en = 1'b1; up = 1'b1;
    for (int i = 1; i < 17; i++) begin
      cycle();
      chk("seq", 32'(gray_w), 32'(seq[i]));
      chk("seq_term", 32'(term_w), (i == 16) ? 32'd1 : 32'd0);
    end

    // Load then count.
    en = 1'b0; load = 1'b1; load_gray = 4'hB;
    cycle();
    chk("load_gray", 32'(gray_w), 32'hB);
    chk("load_bin",  32'(bin_w),  32'hD);
    load = 1'b0; en = 1'b1; up = 1'b1;
    cycle();
    chk("after_load_gray", 32'(gray_w), 32'h9);
    chk("after_load_bin",  32'(bin_w),  32'hE);

    // Down from zero.
    en = 1'b0;
    do_reset();
    en = 1'b1; up = 1'b0;
    cycle();
    chk("down_wrap_bin",  32'(bin_w),  32'hF);
    chk("down_wrap_gray", 32'(gray_w), 32'h8);
    chk("down_wrap_term", 32'(term_w), 32'd1);
    chk("down_sat_bin",   32'(bin_s),  32'h0);
    cycle();
    chk("down2_bin",  32'(bin_w),  32'hE);
    chk("down2_term", 32'(term_w), 32'd0);

    // Saturate at top.
    en = 1'b0; load = 1'b1; load_gray = 4'h8;
    cycle();
    load = 1'b0; en = 1'b1; up = 1'b1;
    repeat (3) begin
      cycle();
      chk("sat_hold_bin",  32'(bin_s),  32'hF);
      chk("sat_hold_gray", 32'(gray_s), 32'h8);
      chk("sat_hold_term", 32'(term_s), 32'd1);
    end

    // Load beats count.
    load = 1'b1; en = 1'b1; up = 1'b1; load_gray = 4'h6;
    cycle();
    chk("ld_pri_bin",  32'(bin_w),  32'h4);
    chk("ld_pri_gray", 32'(gray_w), 32'h6);
    load = 1'b0;

    // Random traffic.
    for (int i = 0; i < 400; i++) begin
      en        = ($urandom_range(0, 3) != 0);
      up        = $urandom_range(0, 1) != 0;
      load      = ($urandom_range(0, 15) == 0);
      load_gray = W'($urandom_range(0, MAXV));
      cycle();
    end

    // Asynchronous reset mid-count.
    load = 1'b1; en = 1'b0; load_gray = 4'hD;
    cycle();
    chk("pre_rst_bin", 32'(bin_w), 32'h9);
    load = 1'b0; en = 1'b1; up = 1'b1;
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    mb_w = 0; mb_s = 0; mt_w = 1'b0; mt_s = 1'b0;
    check_all();
    repeat (2) begin
      @(posedge clk);
      #1;
      check_all();
    end
    @(negedge clk);
    rst_n = 1'b1;
    en = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/gray_counter_n.md
Name: gray_counter_n

Overview:
- Parametrised, registered up/down Gray-code counter that presents both the Gray value and its binary equivalent every cycle.
- Generalises the 4-bit combinational Gray-to-binary converter to WIDTH bits.
- Adds sequential features: count enable, direction, parallel load of a Gray value, and wrap or saturate at terminal count.
- Sits alongside the code converters as the position/sequence source for lab datapaths and pointer logic.

Parameters:
- WIDTH, 4, counter width in bits; legal range 2..32.
- SATURATE, 0, terminal behaviour: 0 = wrap around, 1 = hold at the end value.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- en  in  1  count enable; one step per clock while high.
- up  in  1  direction: 1 = increment, 0 = decrement; sampled only when en=1.
- load  in  1  parallel load strobe.
- load_gray  in  WIDTH  Gray-coded value to load.
- gray  out  WIDTH  registered Gray count.
- bin  out  WIDTH  registered binary equivalent of gray.
- terminal  out  1  one-cycle pulse: a step was taken or attempted at the terminal count.

Behaviour:
- State: a single binary register bin_q. The gray register always equals bin_q ^ (bin_q >> 1). All outputs are registered.
- Reset: rst_n low clears bin=0, gray=0 and terminal=0 asynchronously, including mid-count or mid-load. The first action is taken at the first rising clk edge after rst_n deasserts.
- Latency: every command takes effect on the outputs one cycle after the sampling edge. There is no combinational path from any input to any output.
- Priority: load > en > hold.
- load=1:
  - bin <= gray2bin(load_gray); gray <= load_gray; terminal <= 0.
  - en and up are ignored in that cycle.
- gray2bin rule: b[W-1] = g[W-1]; b[k] = b[k+1] ^ g[k] for k = W-2 down to 0.
- en=1, up=1:
  - If bin != 2^W-1: bin <= bin+1; terminal <= 0.
  - If bin == 2^W-1: terminal <= 1. With SATURATE=0, bin <= 0. With SATURATE=1, bin holds.
- en=1, up=0:
  - If bin != 0: bin <= bin-1; terminal <= 0.
  - If bin == 0: terminal <= 1. With SATURATE=0, bin <= 2^W-1. With SATURATE=1, bin holds.
- en=0 and load=0: all values hold; terminal <= 0.
- Unit-distance invariant: every non-saturated count step changes exactly one bit of gray, including the wrap step. A saturated step changes no bits.
- Direction may reverse on any cycle. There is no turnaround penalty.
- terminal is never high for two consecutive cycles unless consecutive steps are each taken at a terminal value. Example: SATURATE=1 with en held high at the end value.

Decomposition:
- Package gray_pkg holds:
  - function bin2gray(b) = b ^ (b >> 1), written width-generic.
  - localparams for the minimum and maximum WIDTH.
  - the SATURATE mode encodings WRAP=0 and SAT=1.
- Sub-module gray2bin_n: a purely combinational, WIDTH-parametrised converter using the MSB-first XOR prefix chain. It is the direct generalisation of the 4-bit converter and is instantiated once, on load_gray.
- Counter, direction/terminal logic and output registers live in gray_counter_n.

Test Plan:
- WIDTH=4, reset release, en=1, up=1 for 17 cycles -> gray sequence 0,1,3,2,6,7,5,4,C,D,F,E,A,B,9,8,0. bin runs 0..F then 0. terminal=1 only on the cycle the outputs show 0 after F. Exactly one gray bit flips per step.
- load=1 with load_gray=4'hB -> next cycle gray=B, bin=D, terminal=0. Then en=1, up=1 -> gray=9, bin=E.
- From reset, en=1, up=0 with SATURATE=0 -> bin=F, gray=8, terminal=1. The next step gives bin=E, gray=9, terminal=0.
- SATURATE=1: load gray 4'h8 (bin F), then en=1, up=1 for 3 cycles -> bin stays F, gray stays 8, terminal=1 on each of the 3 cycles.
- Simultaneous load=1, en=1, up=1 with load_gray=4'h6 -> bin=4, gray=6. The count step is ignored.
- Mid-count (bin=9), drive rst_n low between clock edges -> bin=0, gray=0, terminal=0 without waiting for clk. Outputs hold 0 while rst_n is low even with en=1.
